// File: rtl/mips_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : mips_bus_pkg                                                |
// | Description: Shared types and constants for the unified memory bus.      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  localparam int                      BYTEEN_MAX_W = 64;
  localparam logic [BYTEEN_MAX_W-1:0] BYTEEN_ALL   = '1;

  // Round-robin between the two ports; a lone requester always wins.
  function automatic grant_e arb_pick(input logic   instr_pend,
                                      input logic   data_pend,
                                      input grant_e last);
    if (instr_pend && data_pend) begin
      return (last == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
    end else if (data_pend) begin
      return GRANT_DATA;
    end else begin
      return GRANT_INSTR;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : bus_timeout_counter                                         |
// | Description: Saturating wait-cycle counter with a sticky overflow flag.  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module bus_timeout_counter #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic flag_o
);

  localparam int             CW    = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0]  c_MAX = CW'(MAX);

  logic [CW-1:0] count_q, count_d;
  logic          flag_q,  flag_d;

  // MAX of zero turns the whole check off.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (MAX != 0) && (count_q != c_MAX)) begin
      count_d = count_q + 1'b1;
    end
    flag_d = flag_q | ((MAX != 0) && (count_d == c_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : mem_bus_arbiter                                             |
// | Description: Merges fetch and data ports onto one waitrequest bus.       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic [DATA_W-1:0]   instr_rdata,
  output logic                instr_valid,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_byteenable,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                stall,
  output logic                bus_error
);

  localparam int BE_W = DATA_W / 8;

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;
  grant_e w_pick;

  logic w_data_pend;
  logic w_grant_i, w_grant_d;
  logic w_complete, w_waiting;

  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] writedata_q;
  logic [BE_W-1:0]   byteenable_q;
  logic              read_q, write_q;
  logic [DATA_W-1:0] instr_rdata_q, data_rdata_q;
  logic              instr_valid_q, data_valid_q;

  assign w_data_pend = data_read | data_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_grant_d) begin
          state_d = BUS_D;
        end else if (w_grant_i) begin
          state_d = BUS_I;
        end
      end
      BUS_I, BUS_D: begin
        if (!waitrequest) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_pick       = arb_pick(instr_req, w_data_pend, last_grant_q);
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_complete   = 1'b0;
    w_waiting    = 1'b0;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (instr_req || w_data_pend) begin
          if (w_pick == GRANT_DATA) begin
            w_grant_d = 1'b1;
          end else begin
            w_grant_i = 1'b1;
          end
        end
      end
      BUS_I: begin
        w_complete = !waitrequest;
        w_waiting  = waitrequest;
        if (!waitrequest) begin
          last_grant_d = GRANT_INSTR;
        end
      end
      BUS_D: begin
        w_complete = !waitrequest;
        w_waiting  = waitrequest;
        if (!waitrequest) begin
          last_grant_d = GRANT_DATA;
        end
      end
      default: begin
      end
    endcase
  end

  // A simultaneous load and store is issued as a store only.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= GRANT_INSTR;
      address_q     <= '0;
      writedata_q   <= '0;
      byteenable_q  <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      instr_valid_q <= w_complete && (state_q == BUS_I);
      data_valid_q  <= w_complete && (state_q == BUS_D);
      if (w_grant_i) begin
        address_q    <= instr_addr;
        byteenable_q <= BYTEEN_ALL[BE_W-1:0];
        read_q       <= 1'b1;
        write_q      <= 1'b0;
      end else if (w_grant_d) begin
        address_q    <= data_addr;
        writedata_q  <= data_wdata;
        byteenable_q <= data_byteenable;
        read_q       <= data_read & ~data_write;
        write_q      <= data_write;
      end else if (w_complete) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
      end
      if (w_complete && read_q) begin
        if (state_q == BUS_I) begin
          instr_rdata_q <= readdata;
        end else begin
          data_rdata_q <= readdata;
        end
      end
    end
  end

  bus_timeout_counter #(
    .MAX (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (w_complete),
    .en_i   (w_waiting),
    .flag_o (bus_error)
  );

  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;
  assign byteenable  = byteenable_q;
  assign instr_rdata = instr_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign instr_valid = instr_valid_q;
  assign data_valid  = data_valid_q;
  assign stall       = (instr_req & ~instr_valid_q) | (w_data_pend & ~data_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_mem_bus_arbiter                                          |
// | Description: Scoreboard bench for the fetch/data bus arbiter.            |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  typedef struct {
    bit          is_instr;
    bit          chk;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_valid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        stall;
  logic        bus_error;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  resp_t mr;
  bus_t  mb;

  int n_total;
  int n_pass;
  int n_fail;
  int ws_plan;
  int ws_cnt;
  bit saw_read;

  logic        prev_rst, prev_stb, prev_wait;
  logic [37:0] prev_ctl;
  logic [31:0] prev_wd;

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_req       (instr_req),
    .instr_addr      (instr_addr),
    .instr_rdata     (instr_rdata),
    .instr_valid     (instr_valid),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_byteenable (data_byteenable),
    .data_rdata      (data_rdata),
    .data_valid      (data_valid),
    .address         (address),
    .read            (read),
    .write           (write),
    .writedata       (writedata),
    .byteenable      (byteenable),
    .waitrequest     (waitrequest),
    .readdata        (readdata),
    .stall           (stall),
    .bus_error       (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return a ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic [31:0] a);
    bus_q.push_back('{rd: 1'b1, wr: 1'b0, addr: a, wdata: 32'h0, be: 4'hF});
    resp_q.push_back('{is_instr: 1'b1, chk: 1'b1, rdata: mem_model(a)});
  endtask

  task automatic push_d(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    bus_q.push_back('{rd: rd & ~wr, wr: wr, addr: a, wdata: wd, be: be});
    resp_q.push_back('{is_instr: 1'b0, chk: rd & ~wr, rdata: mem_model(a)});
  endtask

  // Bus slave: inserts ws_plan wait states per transaction.
  initial begin
    waitrequest = 1'b0;
    readdata    = 32'hFFFF_FFFF;
    ws_cnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (read || write) begin
        if (ws_cnt < ws_plan) begin
          waitrequest = 1'b1;
          readdata    = ~mem_model(address);
          ws_cnt++;
        end else begin
          waitrequest = 1'b0;
          readdata    = mem_model(address);
        end
      end else begin
        ws_cnt      = 0;
        waitrequest = 1'b0;
        readdata    = 32'hFFFF_FFFF;
      end
    end
  end

  // Scoreboard monitor and payload-hold checker.
  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid || data_valid) begin
        check("valid exclusive", {63'b0, instr_valid & data_valid}, 64'd0);
        if (resp_q.size() == 0) begin
          check("resp unexpected", 64'd1, 64'd0);
        end else begin
          mr = resp_q.pop_front();
          check("resp port", {63'b0, instr_valid}, {63'b0, mr.is_instr});
          if (mr.chk) begin
            check("resp rdata", {32'b0, mr.is_instr ? instr_rdata : data_rdata}, {32'b0, mr.rdata});
          end
        end
      end
      if ((read || write) && !waitrequest) begin
        if (bus_q.size() == 0) begin
          check("bus unexpected", 64'd1, 64'd0);
        end else begin
          mb = bus_q.pop_front();
          check("bus strobes", {62'b0, read, write}, {62'b0, mb.rd, mb.wr});
          check("bus address", {32'b0, address}, {32'b0, mb.addr});
          check("bus byteenable", {60'b0, byteenable}, {60'b0, mb.be});
          if (mb.wr) check("bus writedata", {32'b0, writedata}, {32'b0, mb.wdata});
        end
      end
      if (!prev_rst && prev_stb && prev_wait) begin
        check("hold ctl", {26'b0, read, write, byteenable, address}, {26'b0, prev_ctl});
        check("hold wdata", {32'b0, writedata}, {32'b0, prev_wd});
      end
    end
    prev_rst  = reset;
    prev_stb  = read | write;
    prev_wait = waitrequest;
    prev_ctl  = {read, write, byteenable, address};
    prev_wd   = writedata;
  end

  task automatic run_until(input bit instr, input int exp_n, input string tag);
    int n;
    n        = 0;
    saw_read = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      if (read) saw_read = 1'b1;
      if (instr ? instr_valid : data_valid) break;
      next_cycle;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_n));
    next_cycle;
    if (instr) begin
      instr_req = 1'b0;
    end else begin
      data_read  = 1'b0;
      data_write = 1'b0;
    end
  endtask

  task automatic data_txn(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int ws, input string tag);
    next_cycle;
    data_read       = rd;
    data_write      = wr;
    data_addr       = a;
    data_wdata      = wd;
    data_byteenable = be;
    ws_plan         = ws;
    push_d(rd, wr, a, wd, be);
    run_until(1'b0, 2 + ws, tag);
  endtask

  task automatic contend(input bit data_first, input logic [31:0] ia,
                         input logic [31:0] da, input string tag);
    bit got_i, got_d, both;
    int n;
    got_i = 1'b0;
    got_d = 1'b0;
    both  = 1'b0;
    next_cycle;
    instr_req       = 1'b1;
    instr_addr      = ia;
    data_read       = 1'b1;
    data_addr       = da;
    data_byteenable = 4'hF;
    ws_plan         = 1;
    if (data_first) begin
      push_d(1'b1, 1'b0, da, 32'h0, 4'hF);
      push_i(ia);
    end else begin
      push_i(ia);
      push_d(1'b1, 1'b0, da, 32'h0, 4'hF);
    end
    for (n = 0; n < 40 && !(got_i && got_d); n++) begin
      @(negedge clk);
      if (instr_valid && data_valid) both = 1'b1;
      if (instr_valid) got_i = 1'b1;
      if (data_valid)  got_d = 1'b1;
      next_cycle;
      if (got_i) instr_req = 1'b0;
      if (got_d) data_read = 1'b0;
    end
    check({tag, " completed"}, {62'b0, got_i, got_d}, 64'd3);
    check({tag, " cycles"}, 64'(n), 64'd8);
    check({tag, " overlap"}, {63'b0, both}, 64'd0);
  endtask

  task automatic do_reset();
    next_cycle;
    reset      = 1'b1;
    instr_req  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    next_cycle;
    resp_q.delete();
    bus_q.delete();
    ws_plan = 0;
    next_cycle;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int extra;
    n_total = 0; n_pass = 0; n_fail = 0; ws_plan = 0;
    reset = 1'b1; instr_req = 1'b0; instr_addr = '0;
    data_read = 1'b0; data_write = 1'b0; data_addr = '0;
    data_wdata = '0; data_byteenable = '0;

    // Reset state
    next_cycle;
    next_cycle;
    @(negedge clk);
    check("rst strobes", {60'b0, read, write, instr_valid, data_valid}, 64'd0);
    check("rst bus_error/stall", {62'b0, bus_error, stall}, 64'd0);
    check("rst address", {32'b0, address}, 64'd0);
    check("rst writedata", {32'b0, writedata}, 64'd0);
    check("rst rdata", {instr_rdata, data_rdata}, 64'd0);
    check("rst byteenable", {60'b0, byteenable}, 64'd0);

    // Zero-wait fetch
    next_cycle;
    reset = 1'b0;
    next_cycle;
    instr_req = 1'b1; instr_addr = 32'hBFC0_0000; ws_plan = 0;
    push_i(32'hBFC0_0000);
    @(negedge clk);
    check("fetch c0 read", {63'b0, read}, 64'd0);
    check("fetch c0 stall", {63'b0, stall}, 64'd1);
    next_cycle;
    @(negedge clk);
    check("fetch c1 read", {63'b0, read}, 64'd1);
    check("fetch c1 address", {32'b0, address}, 64'hBFC0_0000);
    check("fetch c1 byteenable", {60'b0, byteenable}, 64'hF);
    check("fetch c1 stall", {63'b0, stall}, 64'd1);
    next_cycle;
    @(negedge clk);
    check("fetch c2 valid", {63'b0, instr_valid}, 64'd1);
    check("fetch c2 rdata", {32'b0, instr_rdata}, 64'h2402_0005);
    check("fetch c2 stall", {63'b0, stall}, 64'd0);
    next_cycle;
    instr_req = 1'b0;
    @(negedge clk);
    check("fetch c3 valid pulse", {63'b0, instr_valid}, 64'd0);

    // Store with two wait states
    data_txn(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'h3, 2, "store ws2");
    check("store no read", {63'b0, saw_read}, 64'd0);

    // Contention and alternation
    do_reset();
    contend(1'b1, 32'h0000_0100, 32'h0000_2040, "contend data first");
    data_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, "lone load");
    contend(1'b0, 32'h0000_0104, 32'h0000_3004, "contend fetch first");

    // Reset in the second wait cycle of a fetch
    do_reset();
    next_cycle;
    instr_req = 1'b1; instr_addr = 32'h0000_0400; ws_plan = 5;
    push_i(32'h0000_0400);
    next_cycle;
    @(negedge clk);
    check("rm wait1 read", {62'b0, read, waitrequest}, 64'd3);
    next_cycle;
    reset = 1'b1;
    next_cycle;
    resp_q.delete();
    bus_q.delete();
    ws_plan = 0;
    @(negedge clk);
    check("rm after reset", {61'b0, read, instr_valid, stall}, 64'd1);
    next_cycle;
    reset = 1'b0;
    push_i(32'h0000_0400);
    run_until(1'b1, 2, "rm reissue");

    // Illegal read+write
    data_txn(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1, "illegal rw");
    check("illegal no read", {63'b0, saw_read}, 64'd0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (data_valid) extra++;
      next_cycle;
    end
    check("illegal single pulse", 64'(extra), 64'd0);

    // Timeout with TIMEOUT=4
    do_reset();
    next_cycle;
    instr_req = 1'b1; instr_addr = 32'hBFC0_0004; ws_plan = 6;
    push_i(32'hBFC0_0004);
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      next_cycle;
      @(negedge clk);
      if (c == 4) check("timeout before 4th", {63'b0, bus_error}, 64'd0);
    end
    check("timeout set", {63'b0, bus_error}, 64'd1);
    next_cycle;
    run_until(1'b1, 2, "timeout fetch");
    @(negedge clk);
    check("timeout sticky", {63'b0, bus_error}, 64'd1);
    do_reset();
    @(negedge clk);
    check("timeout cleared", {63'b0, bus_error}, 64'd0);

    check("scoreboard drained", 64'(resp_q.size() + bus_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified memory bus between the instruction-fetch port and the data port of the 5-instruction harvard core, turning it into a single-bus CPU.
- Holds one bus transaction at a time and waits on waitrequest.
- Registers read data back to the requester that issued it.
- Drives a stall to the core while any request is still pending.

Parameters:
ADDR_W, 32, address width of both ports and of the bus
DATA_W, 32, data width; byteenable width is DATA_W/8
TIMEOUT, 255, number of consecutive waitrequest-high cycles before bus_error is set; 0 disables the check

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
instr_req  in  1  fetch request, held high until instr_valid
instr_addr  in  ADDR_W  fetch address (instr_read_addr)
instr_rdata  out  DATA_W  fetched word, registered
instr_valid  out  1  one-cycle completion pulse for fetch
data_read  in  1  data load request, held until data_valid
data_write  in  1  data store request, held until data_valid
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_byteenable  in  DATA_W/8  store/load byte lanes
data_rdata  out  DATA_W  loaded word, registered
data_valid  out  1  one-cycle completion pulse for data
address  out  ADDR_W  bus address
read  out  1  bus read strobe
write  out  1  bus write strobe
writedata  out  DATA_W  bus write data
byteenable  out  DATA_W/8  bus byte lanes (all ones for fetch)
waitrequest  in  1  bus not ready; strobes and payload held while high
readdata  in  DATA_W  bus read data, valid in the cycle read=1 and waitrequest=0
stall  out  1  core freeze
bus_error  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, BUS_I, BUS_D, DONE. Reset (any state, including mid-transaction) forces IDLE. Reset values:
  - read, write, instr_valid, data_valid, bus_error = 0
  - address, writedata, instr_rdata, data_rdata = 0
  - byteenable = 0
  - last_grant = INSTR
- IDLE:
  - Only data requests pending -> BUS_D. Only instr_req pending -> BUS_I.
  - Both pending: grant the side not granted last (last_grant flip). After reset, data wins first.
  - Grant latches address, writedata and byteenable into output registers. Strobe rises the next cycle, which is the first cycle of BUS_x.
- data_read and data_write both high is illegal. The block treats it as a write and issues no read.
- BUS_x: hold the strobe and payload constant while waitrequest=1.
- Completion cycle is the cycle the strobe is high and waitrequest=0:
  - Reads capture readdata into the matching *_rdata.
  - Strobe drops, state goes to DONE, last_grant is updated.
- DONE (1 cycle): the matching *_valid is high. The requester deasserts its request in the following cycle. DONE -> IDLE unconditionally and does not arbitrate.
- Minimum latency, request to valid: 3 cycles (IDLE, BUS_x, DONE) with zero wait states. Each wait state adds 1 cycle.
- A pending request on the other port stays pending and is served on the next IDLE.
- stall = (instr_req & ~instr_valid) | ((data_read|data_write) & ~data_valid). It is combinational, so stall is low in the DONE cycle of the last outstanding request.
- Timeout counter:
  - Increments each BUS_x cycle with waitrequest=1 and clears on completion.
  - Reaching TIMEOUT sets bus_error, cleared only by reset. The transaction is not aborted.
  - The counter saturates and does not wrap.
- Both *_valid outputs are never high in the same cycle.

Decomposition:
- Shared package (mips_bus_pkg): state enum {IDLE, BUS_I, BUS_D, DONE}, grant enum {GRANT_INSTR, GRANT_DATA}, BYTEEN_ALL constant.
- One natural sub-module, bus_timeout_counter: a saturating counter with clear/enable and a sticky flag. Everything else stays flat.

Test Plan:
- Zero-wait fetch: instr_req=1, instr_addr=0xBFC00000, readdata=0x24020005, waitrequest=0 -> read=1 at cycle 1 with address 0xBFC00000 and byteenable=0xF; instr_valid=1 at cycle 2 with instr_rdata=0x24020005; stall low at cycle 2.
- Store with 2 wait states: data_write=1, data_addr=0x1000, data_wdata=0xDEADBEEF, byteenable=0x3, waitrequest high 2 cycles -> write, address and writedata held 3 cycles; data_valid at cycle 4; read never asserted.
- Contention: instr_req and data_read both high from reset -> data served first, then fetch. On the next simultaneous request fetch wins (alternation). No overlapping strobes.
- Reset mid-transaction: reset at the second wait cycle of BUS_I -> next cycle read=0, state IDLE, no instr_valid. The request is reissued after reset is released.
- Timeout: TIMEOUT=4, waitrequest stuck high -> bus_error rises after the 4th wait cycle and stays high after waitrequest drops and the transaction completes. Cleared only by reset.
- Illegal read+write: data_read=data_write=1 -> only write is asserted; data_valid pulses once.
